// File: rtl/demux_serial_dispatcher.sv
// Serializes addressed words LSB-first onto din with a frame-stable channel select for a 1-to-8 demux.
// Optional build macro DEMUX_DISPATCH_PARITY_EN appends an even-parity bit after the MSB of every frame.
module demux_serial_dispatcher #(
  parameter int DATA_W     = 8,
  parameter int GAP_CYCLES = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic [2:0]        in_dest,
  output logic              din,
  output logic [2:0]        sel,
  output logic              frame_active,
  output logic              frame_done
);

`ifdef DEMUX_DISPATCH_PARITY_EN
  localparam int FRAME_LEN = DATA_W + 1;
`else
  localparam int FRAME_LEN = DATA_W;
`endif

  localparam int CNT_W = $clog2(FRAME_LEN + 1);
  localparam int GAP_W = $clog2(GAP_CYCLES + 2);

  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(FRAME_LEN - 1);
  localparam logic [CNT_W-1:0] PRE_LAST = CNT_W'(FRAME_LEN - 2);
  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

`ifdef DEMUX_DISPATCH_PARITY_EN
  localparam logic [CNT_W-1:0] MSB_BIT = CNT_W'(DATA_W - 1);
  logic parity_bit;
`endif

  typedef enum logic [1:0] {IDLE, SHIFT, GAP} state_t;

  state_t            state;
  logic [DATA_W-1:0] shift_reg;
  logic [CNT_W-1:0]  bit_cnt;
  logic [GAP_W-1:0]  gap_cnt;

  assign in_ready = (state == IDLE);

  // din is registered one bit ahead: the accept edge already loads in_data[0],
  // so shift_reg holds only the bits still to be sent.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      shift_reg    <= '0;
      bit_cnt      <= '0;
      gap_cnt      <= '0;
      din          <= 1'b0;
      sel          <= 3'd0;
      frame_active <= 1'b0;
      frame_done   <= 1'b0;
`ifdef DEMUX_DISPATCH_PARITY_EN
      parity_bit   <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          din          <= 1'b0;
          frame_active <= 1'b0;
          frame_done   <= 1'b0;
          if (in_valid) begin
            shift_reg    <= in_data >> 1;
            din          <= in_data[0];
            sel          <= in_dest;
            bit_cnt      <= '0;
            frame_active <= 1'b1;
`ifdef DEMUX_DISPATCH_PARITY_EN
            parity_bit   <= ^in_data;
`endif
            state        <= SHIFT;
          end
        end

        SHIFT: begin
          if (bit_cnt == LAST_BIT) begin
            din          <= 1'b0;
            frame_active <= 1'b0;
            frame_done   <= 1'b0;
            gap_cnt      <= '0;
            state        <= (GAP_CYCLES > 0) ? GAP : IDLE;
          end else begin
            bit_cnt    <= bit_cnt + CNT_W'(1);
            frame_done <= (bit_cnt == PRE_LAST);
            shift_reg  <= shift_reg >> 1;
`ifdef DEMUX_DISPATCH_PARITY_EN
            din        <= (bit_cnt == MSB_BIT) ? parity_bit : shift_reg[0];
`else
            din        <= shift_reg[0];
`endif
          end
        end

        GAP: begin
          din          <= 1'b0;
          frame_active <= 1'b0;
          frame_done   <= 1'b0;
          if (gap_cnt == GAP_LAST) begin
            state <= IDLE;
          end else begin
            gap_cnt <= gap_cnt + GAP_W'(1);
          end
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
